// File: rtl/umi_arbiter.sv
// Packet-aware N-input arbiter for a shared UMI output port.
// Grants are combinational from IDLE and held from the first beat through the EOM beat.
module umi_arbiter #(
   parameter int N    = 4,
   parameter int AGEW = 4,
   parameter int AGE  = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     arbmode,
   input  logic [N-1:0]   arbmask,
   input  logic [N-1:0]   req_valid,
   input  logic [N-1:0]   req_eom,
   output logic [N-1:0]   req_ready,
   output logic [N-1:0]   grant,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           locked
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   lockid_q, lockid_d;
   logic [PW-1:0]   rr_q, rr_d;

   logic [N-1:0]    eligible;
   logic [N-1:0]    aged;
   logic [N-1:0]    grant_int;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   rr_idx;
   logic [PW-1:0]   owner;
   logic            win_any;
   logic            active;
   logic            valid_int;
   logic            done;

   function automatic logic [PW-1:0] lowest(input logic [N-1:0] v);
      logic [PW-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) r = PW'(i);
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
      logic [PW-1:0] r;
      if (int'(w) == N - 1) r = '0;
      else                  r = w + 1'b1;
      return r;
   endfunction

   assign eligible = req_valid & ~arbmask;
   assign win_any  = |eligible;

   // Descending offset scan leaves the closest eligible input at/after the pointer.
   always_comb begin
      int j;
      j      = 0;
      rr_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(rr_q) + k;
         if (j >= N) j = j - N;
         if (eligible[j]) rr_idx = PW'(j);
      end
   end

   always_comb begin
      win_idx = lowest(eligible);
      case (arbmode)
         2'd0: win_idx = lowest(eligible);
         2'd2: begin
            if (|(eligible & aged)) win_idx = lowest(eligible & aged);
            else                    win_idx = lowest(eligible);
         end
         default: win_idx = rr_idx;
      endcase
   end

   assign owner  = (state_q == LOCKED) ? lockid_q : win_idx;
   assign active = (state_q == LOCKED) | win_any;

   always_comb begin
      grant_int = '0;
      if (active) grant_int[owner] = 1'b1;
   end

   assign valid_int = |(grant_int & req_valid);
   assign done      = valid_int & out_ready & req_eom[owner];

   // Any grant that does not complete a packet this cycle becomes a held lock.
   always_comb begin
      state_d  = state_q;
      lockid_d = lockid_q;
      rr_d     = rr_q;
      if (done) begin
         state_d = IDLE;
         rr_d    = next_ptr(owner);
      end else if (state_q == IDLE && win_any) begin
         state_d  = LOCKED;
         lockid_d = win_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         lockid_q <= '0;
         rr_q     <= '0;
      end else begin
         state_q  <= state_d;
         lockid_q <= lockid_d;
         rr_q     <= rr_d;
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_wait
         logic [AGEW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (!eligible[gi] || (done && grant_int[gi])) cnt_d = '0;
            else if (!grant_int[gi] && (cnt_q != {AGEW{1'b1}})) cnt_d = cnt_q + 1'b1;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
         end

         assign aged[gi] = (cnt_q >= AGEW'(AGE));
      end
   endgenerate

   assign grant     = reset ? '0 : grant_int;
   assign req_ready = grant & {N{out_ready}};
   assign out_valid = |(grant & req_valid);
   assign locked    = ~reset & (state_q == LOCKED);

endmodule

// File: tb/tb_umi_arbiter.sv
// Testbench for umi_arbiter: directed vector table, hand sequences, and random traffic
// checked against a queue-based priority-list model.
module tb_umi_arbiter;

   localparam int N    = 4;
   localparam int AGEW = 4;
   localparam int AGE  = 8;
   localparam int WMAX = (1 << AGEW) - 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [1:0]     arbmode = '0;
   logic [N-1:0]   arbmask = '0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_eom = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           locked;

   umi_arbiter #(.N(N), .AGEW(AGEW), .AGE(AGE)) dut (
      .clk       (clk),
      .reset     (reset),
      .arbmode   (arbmode),
      .arbmask   (arbmask),
      .req_valid (req_valid),
      .req_eom   (req_eom),
      .req_ready (req_ready),
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: packet owner, round-robin pointer, wait ages.
   bit           m_locked;
   int           m_owner;
   int           m_rr;
   int           m_wait[N];
   bit           e_act;
   int           e_owner;
   logic [N-1:0] e_grant;
   logic         e_valid;

   typedef struct {
      logic [1:0]   mode;
      logic [N-1:0] mask;
      logic [N-1:0] valid;
      logic [N-1:0] eom;
      logic         rdy;
      logic [N-1:0] eg;
      logic         ev;
      logic         el;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_locked = 1'b0;
      m_owner  = 0;
      m_rr     = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
   endfunction

   function automatic void model_eval();
      logic [N-1:0] elig;
      int order[$];
      elig    = req_valid & ~arbmask;
      e_act   = 1'b0;
      e_owner = 0;
      if (m_locked) begin
         e_act   = 1'b1;
         e_owner = m_owner;
      end else begin
         for (int k = 0; k < N; k++)
            order.push_back((arbmode == 2'd1 || arbmode == 2'd3) ? (m_rr + k) % N : k);
         if (arbmode == 2'd2)
            foreach (order[k])
               if (!e_act && elig[order[k]] && m_wait[order[k]] >= AGE) begin
                  e_act   = 1'b1;
                  e_owner = order[k];
               end
         foreach (order[k])
            if (!e_act && elig[order[k]]) begin
               e_act   = 1'b1;
               e_owner = order[k];
            end
      end
      e_grant = '0;
      if (e_act) e_grant[e_owner] = 1'b1;
      e_valid = e_act && req_valid[e_owner];
   endfunction

   function automatic void model_update();
      logic [N-1:0] elig;
      bit done;
      elig = req_valid & ~arbmask;
      done = e_valid && out_ready && req_eom[e_owner];
      for (int i = 0; i < N; i++) begin
         if (!elig[i] || (done && e_owner == i)) m_wait[i] = 0;
         else if (!(e_act && e_owner == i))      m_wait[i] = (m_wait[i] >= WMAX) ? WMAX : m_wait[i] + 1;
      end
      if (done) begin
         m_locked = 1'b0;
         m_rr     = (e_owner + 1) % N;
      end else if (e_act) begin
         m_locked = 1'b1;
         m_owner  = e_owner;
      end
   endfunction

   task automatic apply(input logic [1:0] md, input logic [N-1:0] mk, input logic [N-1:0] v,
                        input logic [N-1:0] e, input logic r);
      @(negedge clk);
      arbmode   = md;
      arbmask   = mk;
      req_valid = v;
      req_eom   = e;
      out_ready = r;
      #2;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '1;
      req_eom   = '1;
      out_ready = 1'b1;
      model_reset();
      #2;
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_ready", 32'(req_ready), 32'h0);
      chk("reset_valid", 32'(out_valid), 32'h0);
      chk("reset_locked", 32'(locked), 32'h0);
      @(negedge clk);
      reset     = 1'b0;
      req_valid = '0;
   endtask

   function automatic void add(input logic [1:0] md, input logic [N-1:0] mk, input logic [N-1:0] v,
                               input logic [N-1:0] e, input logic r, input logic [N-1:0] eg,
                               input logic ev, input logic el);
      vec_t t;
      t.mode = md; t.mask = mk; t.valid = v; t.eom = e; t.rdy = r;
      t.eg = eg; t.ev = ev; t.el = el;
      tbl.push_back(t);
   endfunction

   initial begin
      model_reset();

      // Fixed priority: input 1 always beats input 3. Pointer ends at 2.
      for (int i = 0; i < 3; i++) add(2'd0, 4'h0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0);
      // Round-robin from pointer 2, single-beat packets, no idle cycles.
      add(2'd1, 4'h0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0);
      add(2'd1, 4'h0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0);
      add(2'd1, 4'h0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0);
      add(2'd1, 4'h0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0);
      // Three-beat packet on input 2 while input 0 waits; then wrap to input 0.
      add(2'd1, 4'h0, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 1'b0);
      add(2'd1, 4'h0, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 1'b1);
      add(2'd1, 4'h0, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 1'b1);
      add(2'd1, 4'h0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0);
      add(2'd1, 4'h0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
      // Backpressure on input 1, late request from input 0, one bubble, then EOM.
      add(2'd1, 4'h0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) add(2'd1, 4'h0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1);
      add(2'd1, 4'h0, 4'b0011, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1);
      add(2'd1, 4'h0, 4'b0001, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b1);
      add(2'd1, 4'h0, 4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1);
      add(2'd1, 4'h0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0);
      // Masked input 0 loses to input 1 in fixed priority.
      add(2'd0, 4'b0001, 4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0);

      repeat (2) @(negedge clk);
      do_reset();

      foreach (tbl[i]) begin
         apply(tbl[i].mode, tbl[i].mask, tbl[i].valid, tbl[i].eom, tbl[i].rdy);
         $display("vec %0d: valid=%b rdy=%b grant=%b out_valid=%b locked=%b", i,
                  req_valid, out_ready, grant, out_valid, locked);
         chk("tbl_grant", 32'(grant), 32'(tbl[i].eg));
         chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
         chk("tbl_locked", 32'(locked), 32'(tbl[i].el));
         chk("tbl_ready", 32'(req_ready), 32'(tbl[i].rdy ? tbl[i].eg : 4'b0000));
         tick();
      end

      // Aged priority: input 3 wins on its 9th waiting cycle, then waits a full 9 again.
      do_reset();
      for (int c = 1; c <= 18; c++) begin
         apply(2'd2, 4'h0, 4'b1001, 4'b1111, 1'b1);
         $display("aged cycle %0d: grant=%b", c, grant);
         chk("aged_grant", 32'(grant), (c == 9 || c == 18) ? 32'h8 : 32'h1);
         tick();
      end

      // Mask applied mid-packet keeps the lock; async reset abandons it.
      apply(2'd0, 4'h0, 4'b0010, 4'b0000, 1'b1);
      $display("lock start: grant=%b locked=%b", grant, locked);
      chk("mlock_grant0", 32'(grant), 32'h2);
      chk("mlock_locked0", 32'(locked), 32'h0);
      tick();
      apply(2'd0, 4'b0010, 4'b0010, 4'b0000, 1'b1);
      $display("mask mid-packet: grant=%b locked=%b", grant, locked);
      chk("mlock_grant1", 32'(grant), 32'h2);
      chk("mlock_locked1", 32'(locked), 32'h1);
      #1 reset = 1'b1;
      model_reset();
      #1;
      $display("async reset: grant=%b locked=%b out_valid=%b", grant, locked, out_valid);
      chk("areset_grant", 32'(grant), 32'h0);
      chk("areset_locked", 32'(locked), 32'h0);
      chk("areset_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #2;
      model_eval();
      $display("post reset masked: grant=%b out_valid=%b", grant, out_valid);
      chk("pmask_grant", 32'(grant), 32'h0);
      chk("pmask_valid", 32'(out_valid), 32'h0);
      tick();
      apply(2'd0, 4'b0010, 4'b0011, 4'b0011, 1'b1);
      $display("post reset other: grant=%b", grant);
      chk("pmask_grant2", 32'(grant), 32'h1);
      tick();

      // Random traffic against the reference model.
      begin
         logic [1:0] cur_mode;
         logic [N-1:0] mk;
         cur_mode = 2'($urandom_range(0, 3));
         for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
            mk = '0;
            for (int b = 0; b < N; b++) mk[b] = ($urandom_range(0, 7) == 0);
            apply(cur_mode, mk, N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
            $display("rand %0d: mode=%0d mask=%b valid=%b eom=%b rdy=%b grant=%b exp=%b", c,
                     arbmode, arbmask, req_valid, req_eom, out_ready, grant, e_grant);
            chk("rand_grant", 32'(grant), 32'(e_grant));
            chk("rand_valid", 32'(out_valid), 32'(e_valid));
            chk("rand_ready", 32'(req_ready), 32'(out_ready ? e_grant : 4'b0000));
            chk("rand_locked", 32'(locked), 32'(m_locked));
            chk("rand_onehot", 32'($onehot0(grant)), 32'h1);
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
